// File: rtl/rep_seq_monitor.sv
// Multi-channel checker for "$rose(trig) |-> qual throughout ev[*N] / ev[->N] / ev[=N]"
// with a bounded evaluation window, per-channel pass/fail pulses and fail causes.
module rep_seq_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4,
    parameter int WIN_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_cfg_mode,
    input  logic [CNT_W-1:0]      i_cfg_count,
    input  logic [WIN_W-1:0]      i_cfg_window,
    input  logic [NUM_CH-1:0]     i_trig,
    input  logic [NUM_CH-1:0]     i_ev,
    input  logic [NUM_CH-1:0]     i_qual,
    output logic [NUM_CH-1:0]     o_busy,
    output logic [NUM_CH-1:0]     o_pass,
    output logic [NUM_CH-1:0]     o_fail,
    output logic [2*NUM_CH-1:0]   o_fail_cause,
    output logic [NUM_CH-1:0]     o_drop
);

    localparam logic [1:0] MODE_CONSEC    = 2'd0;
    localparam logic [1:0] MODE_NONCONSEC = 2'd2;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_QUAL   = 2'd1;
    localparam logic [1:0] CAUSE_SHORT  = 2'd2;
    localparam logic [1:0] CAUSE_EXCESS = 2'd3;

    localparam logic [WIN_W:0] WIN_FULL = {1'b1, {WIN_W{1'b0}}};
    localparam logic [WIN_W:0] WIN_ONE  = {{WIN_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] CNT_MAX  = {(CNT_W+1){1'b1}};

    typedef enum logic {
        ST_IDLE,
        ST_ARMED
    } state_t;

    logic [NUM_CH-1:0] r_trig_q;
    logic [NUM_CH-1:0] w_rise;
    logic [WIN_W:0]    w_cfg_win;

    assign w_rise    = i_trig & ~r_trig_q;
    // A programmed window of zero means the full 2**WIN_W cycles.
    assign w_cfg_win = (i_cfg_window == '0) ? WIN_FULL : {1'b0, i_cfg_window};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_trig_q <= '0;
        end else begin
            r_trig_q <= i_trig;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            state_t           r_state;
            state_t           w_state_next;
            logic [1:0]       r_mode;
            logic [CNT_W-1:0] r_count;
            logic [WIN_W:0]   r_win;
            logic [WIN_W:0]   r_k;
            logic [CNT_W:0]   r_ev_cnt;
            logic             r_pass;
            logic             r_fail;
            logic [1:0]       r_cause;
            logic             r_drop;

            logic             w_launch;
            logic             w_active;
            logic [1:0]       w_mode;
            logic [CNT_W-1:0] w_count;
            logic [WIN_W:0]   w_win;
            logic [WIN_W:0]   w_k;
            logic [CNT_W:0]   w_cnt_prev;
            logic [CNT_W:0]   w_cnt_now;
            logic             w_last;
            logic             w_reached;
            logic             w_excess;
            logic             w_pass_next;
            logic             w_fail_next;
            logic [1:0]       w_cause_next;
            logic             w_drop_next;
            logic [WIN_W:0]   w_k_next;
            logic [CNT_W:0]   w_cnt_next;

            always_comb begin
                w_state_next = r_state;
                w_pass_next  = 1'b0;
                w_fail_next  = 1'b0;
                w_cause_next = CAUSE_NONE;
                w_k_next     = '0;
                w_cnt_next   = '0;

                w_launch = (r_state == ST_IDLE) && w_rise[gi];
                w_active = w_launch || (r_state == ST_ARMED);

                // The rise cycle is evaluated cycle 0, so it must use the live config.
                if (r_state == ST_IDLE) begin
                    w_mode     = i_cfg_mode;
                    w_count    = i_cfg_count;
                    w_win      = w_cfg_win;
                    w_k        = '0;
                    w_cnt_prev = '0;
                end else begin
                    w_mode     = r_mode;
                    w_count    = r_count;
                    w_win      = r_win;
                    w_k        = r_k;
                    w_cnt_prev = r_ev_cnt;
                end

                if (w_cnt_prev == CNT_MAX) begin
                    w_cnt_now = w_cnt_prev;
                end else begin
                    w_cnt_now = w_cnt_prev + {{CNT_W{1'b0}}, i_ev[gi]};
                end

                w_last    = (w_k == (w_win - WIN_ONE));
                w_reached = (w_cnt_now >= {1'b0, w_count});
                w_excess  = (w_cnt_now >  {1'b0, w_count});

                if (w_active) begin
                    w_state_next = ST_ARMED;
                    w_k_next     = w_k + WIN_ONE;
                    w_cnt_next   = w_cnt_now;

                    if (!i_qual[gi]) begin
                        w_fail_next  = 1'b1;
                        w_cause_next = CAUSE_QUAL;
                    end else begin
                        case (w_mode)
                            MODE_CONSEC: begin
                                if (w_reached) begin
                                    w_pass_next = 1'b1;
                                end else if (!i_ev[gi] || w_last) begin
                                    w_fail_next  = 1'b1;
                                    w_cause_next = CAUSE_SHORT;
                                end
                            end
                            MODE_NONCONSEC: begin
                                if (w_excess) begin
                                    w_fail_next  = 1'b1;
                                    w_cause_next = CAUSE_EXCESS;
                                end else if (w_last) begin
                                    if (w_cnt_now == {1'b0, w_count}) begin
                                        w_pass_next = 1'b1;
                                    end else begin
                                        w_fail_next  = 1'b1;
                                        w_cause_next = CAUSE_SHORT;
                                    end
                                end
                            end
                            default: begin
                                // GOTO, and the reserved encoding behaves identically.
                                if (w_reached) begin
                                    w_pass_next = 1'b1;
                                end else if (w_last) begin
                                    w_fail_next  = 1'b1;
                                    w_cause_next = CAUSE_SHORT;
                                end
                            end
                        endcase
                    end

                    if (w_pass_next || w_fail_next) begin
                        w_state_next = ST_IDLE;
                        w_k_next     = '0;
                        w_cnt_next   = '0;
                    end
                end

                w_drop_next = w_rise[gi] && (r_state == ST_ARMED);
            end

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_state  <= ST_IDLE;
                    r_mode   <= '0;
                    r_count  <= '0;
                    r_win    <= '0;
                    r_k      <= '0;
                    r_ev_cnt <= '0;
                    r_pass   <= 1'b0;
                    r_fail   <= 1'b0;
                    r_cause  <= CAUSE_NONE;
                    r_drop   <= 1'b0;
                end else begin
                    r_state  <= w_state_next;
                    if (w_launch) begin
                        r_mode  <= i_cfg_mode;
                        r_count <= i_cfg_count;
                        r_win   <= w_cfg_win;
                    end
                    r_k      <= w_k_next;
                    r_ev_cnt <= w_cnt_next;
                    r_pass   <= w_pass_next;
                    r_fail   <= w_fail_next;
                    r_cause  <= w_cause_next;
                    r_drop   <= w_drop_next;
                end
            end

            assign o_busy[gi]             = i_rst_n && w_active;
            assign o_pass[gi]             = r_pass;
            assign o_fail[gi]             = r_fail;
            assign o_fail_cause[2*gi +: 2] = r_cause;
            assign o_drop[gi]             = r_drop;
        end
    endgenerate

endmodule
